// File: rtl/vram_pkg.sv
// Shared widths, write-port record and arbiter state encoding for the VRAM
// write arbiter.
package vram_pkg;

  localparam int VRAM_AW  = 11;
  localparam int VRAM_DW  = 32;
  localparam int VRAM_BEW = 4;

  typedef struct packed {
    logic                wren;
    logic [VRAM_AW-1:0]  waddr;
    logic [VRAM_DW-1:0]  wdata;
    logic [VRAM_BEW-1:0] be;
  } vram_wr_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request at or above ptr, with
// wrap-around, returned as one-hot, index and valid.
module rr_priority_picker #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          valid
);

  always_comb begin
    int pos;
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    pos    = 0;
    for (int k = 0; k < N; k++) begin
      // Modulo keeps the search in range even for unreachable pointer codes.
      pos = (int'(ptr) + k) % N;
      if (!valid && req[pos]) begin
        valid       = 1'b1;
        idx         = IW'(pos);
        onehot[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vram_write_arbiter.sv
// Round-robin, burst-locking arbiter for the text-mode VRAM write port.
// Optional macro VRAM_ARB_VBLANK_GATE_EN: new bursts start only while BLANK_IN=1.
module vram_write_arbiter
  import vram_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int TIMEOUT = 15
) (
  input  logic                        CLK,
  input  logic                        RESET_N,
  input  logic [NUM_REQ-1:0]          REQ,
  input  logic [NUM_REQ-1:0]          LAST,
  input  logic [NUM_REQ*VRAM_AW-1:0]  ADDR,
  input  logic [NUM_REQ*VRAM_DW-1:0]  WDATA,
  input  logic [NUM_REQ*VRAM_BEW-1:0] BE,
  input  logic                        BLANK_IN,
  output logic [NUM_REQ-1:0]          GNT,
  output logic                        RAM_WREN,
  output logic [VRAM_AW-1:0]          RAM_WADDR,
  output logic [VRAM_DW-1:0]          RAM_WDATA,
  output logic [VRAM_BEW-1:0]         RAM_BE,
  output logic                        BUSY
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t          state_reg, state_next;
  logic [IW-1:0]       ptr_reg, ptr_next;
  logic [IW-1:0]       owner_reg, owner_next;
  logic [7:0]          cnt_reg, cnt_next;
  vram_wr_t            wr_reg, wr_next;

  logic [NUM_REQ-1:0]  pick_req, pick_onehot, gnt;
  logic [IW-1:0]       pick_idx, sel_idx;
  logic                pick_valid, new_ok, beat;

  logic [VRAM_AW-1:0]  addr_arr [NUM_REQ];
  logic [VRAM_DW-1:0]  data_arr [NUM_REQ];
  logic [VRAM_BEW-1:0] be_arr   [NUM_REQ];
  logic [VRAM_AW-1:0]  sel_addr;
  logic [VRAM_DW-1:0]  sel_data;
  logic [VRAM_BEW-1:0] sel_be;
  logic                sel_last;

  function automatic logic [IW-1:0] inc_wrap(input logic [IW-1:0] v);
    return (v == IW'(NUM_REQ - 1)) ? '0 : v + 1'b1;
  endfunction

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign addr_arr[gi] = ADDR[gi*VRAM_AW +: VRAM_AW];
    assign data_arr[gi] = WDATA[gi*VRAM_DW +: VRAM_DW];
    assign be_arr[gi]   = BE[gi*VRAM_BEW +: VRAM_BEW];
  end

`ifdef VRAM_ARB_VBLANK_GATE_EN
  assign new_ok = BLANK_IN;
`else
  logic unused_blank;
  assign unused_blank = BLANK_IN;
  assign new_ok       = 1'b1;
`endif

  // Blanking gate only affects the search for a new burst, never a locked owner.
  assign pick_req = REQ & {NUM_REQ{new_ok}};

  rr_priority_picker #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_picker (
    .req    (pick_req),
    .ptr    (ptr_reg),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  assign sel_idx = (state_reg == ARB_LOCKED) ? owner_reg : pick_idx;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_be   = '0;
    sel_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_idx == IW'(i)) begin
        sel_addr = addr_arr[i];
        sel_data = data_arr[i];
        sel_be   = be_arr[i];
        sel_last = LAST[i];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    owner_next = owner_reg;
    cnt_next   = cnt_reg;
    gnt        = '0;
    case (state_reg)
      ARB_IDLE: begin
        cnt_next = '0;
        if (pick_valid) begin
          gnt = pick_onehot;
          if (sel_last) begin
            ptr_next = inc_wrap(pick_idx);
          end else begin
            state_next = ARB_LOCKED;
            owner_next = pick_idx;
          end
        end
      end
      ARB_LOCKED: begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (owner_reg == IW'(i)) gnt[i] = REQ[i];
        end
        if (|gnt) begin
          cnt_next = '0;
          if (sel_last) begin
            state_next = ARB_IDLE;
            ptr_next   = inc_wrap(owner_reg);
          end
        end else if (cnt_reg == 8'(TIMEOUT - 1)) begin
          // Owner stalled too long: drop the lock without issuing a beat.
          state_next = ARB_IDLE;
          ptr_next   = inc_wrap(owner_reg);
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      default: begin
        state_next = ARB_IDLE;
      end
    endcase
  end

  assign beat = |(REQ & gnt) & RESET_N;

  always_comb begin
    wr_next      = wr_reg;
    wr_next.wren = beat;
    if (beat) begin
      wr_next.waddr = sel_addr;
      wr_next.wdata = sel_data;
      wr_next.be    = sel_be;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg <= ARB_IDLE;
      ptr_reg   <= '0;
      owner_reg <= '0;
      cnt_reg   <= '0;
      wr_reg    <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      owner_reg <= owner_next;
      cnt_reg   <= cnt_next;
      wr_reg    <= wr_next;
    end
  end

  // Grants are forced low while reset is asserted so no beat is offered then.
  assign GNT       = gnt & {NUM_REQ{RESET_N}};
  assign RAM_WREN  = wr_reg.wren;
  assign RAM_WADDR = wr_reg.waddr;
  assign RAM_WDATA = wr_reg.wdata;
  assign RAM_BE    = wr_reg.be;
  assign BUSY      = (state_reg == ARB_LOCKED);

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Self-checking bench for vram_write_arbiter: inline grant/busy checks plus a
// write scoreboard popped whenever RAM_WREN is seen.
module tb_vram_write_arbiter;

  localparam int N = 3;

  logic            CLK = 1'b0;
  logic            RESET_N = 1'b0;
  logic            BLANK_IN = 1'b1;
  logic [N-1:0]    REQ = '0;
  logic [N-1:0]    LAST = '0;
  logic [N*11-1:0] ADDR = '0;
  logic [N*32-1:0] WDATA = '0;
  logic [N*4-1:0]  BE = '0;
  logic [N-1:0]    GNT;
  logic            RAM_WREN;
  logic [10:0]     RAM_WADDR;
  logic [31:0]     RAM_WDATA;
  logic [3:0]      RAM_BE;
  logic            BUSY;

  int checks = 0;
  int errors = 0;
  logic [46:0] exp_q [$];

  vram_write_arbiter #(.NUM_REQ(N), .TIMEOUT(15)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .REQ(REQ), .LAST(LAST), .ADDR(ADDR),
    .WDATA(WDATA), .BE(BE), .BLANK_IN(BLANK_IN), .GNT(GNT),
    .RAM_WREN(RAM_WREN), .RAM_WADDR(RAM_WADDR), .RAM_WDATA(RAM_WDATA),
    .RAM_BE(RAM_BE), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // Every registered write must match the oldest expected beat.
  always @(posedge CLK) begin
    logic [46:0] e;
    #1;
    if (RAM_WREN === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_write got addr=%h data=%h be=%h", RAM_WADDR, RAM_WDATA, RAM_BE);
      end else begin
        e = exp_q.pop_front();
        if ({RAM_WADDR, RAM_WDATA, RAM_BE} !== e)
          begin errors++; $display("FAIL sb_write got=%h/%h/%h exp=%h/%h/%h", RAM_WADDR, RAM_WDATA, RAM_BE, e[46:36], e[35:4], e[3:0]); end
        else $display("write addr=%h data=%h be=%h ok", RAM_WADDR, RAM_WDATA, RAM_BE);
      end
    end
  end

  task automatic set_src(input int i, input logic last, input logic [10:0] a,
                         input logic [31:0] d, input logic [3:0] b);
    LAST[i] = last;
    ADDR[i*11 +: 11] = a;
    WDATA[i*32 +: 32] = d;
    BE[i*4 +: 4] = b;
  endtask

  task automatic push_src(input int i);
    exp_q.push_back({ADDR[i*11 +: 11], WDATA[i*32 +: 32], BE[i*4 +: 4]});
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    REQ = '0; LAST = '0; BLANK_IN = 1'b1; RESET_N = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    #1;
    checks++;
    if ({GNT, RAM_WREN, RAM_WADDR, RAM_WDATA, RAM_BE, BUSY} !== '0)
      begin errors++; $display("FAIL reset_outputs got gnt=%b wren=%b addr=%h data=%h be=%h busy=%b exp all 0", GNT, RAM_WREN, RAM_WADDR, RAM_WDATA, RAM_BE, BUSY); end
    apply_reset();
  endtask

  task automatic test_single_beat();
    @(negedge CLK);
    set_src(0, 1'b1, 11'h12A, 32'hDEADBEEF, 4'hF);
    REQ = 3'b001;
    #1;
    checks++;
    if (GNT !== 3'b001) begin errors++; $display("FAIL single_gnt got=%b exp=001", GNT); end
    push_src(0);
    @(negedge CLK);
    REQ = '0;
    #1;
    checks++;
    if ({RAM_WREN, RAM_WADDR, RAM_WDATA, RAM_BE} !== {1'b1, 11'h12A, 32'hDEADBEEF, 4'hF})
      begin errors++; $display("FAIL single_latency got wren=%b addr=%h data=%h be=%h exp 1/12a/deadbeef/f", RAM_WREN, RAM_WADDR, RAM_WDATA, RAM_BE); end
    @(negedge CLK);
    #1;
    checks++;
    if (RAM_WREN !== 1'b0) begin errors++; $display("FAIL single_wren_drop got=%b exp=0", RAM_WREN); end
  endtask

  task automatic test_rotation();
    logic [N-1:0] e;
    apply_reset();
    set_src(0, 1'b1, 11'h100, 32'hA0000000, 4'hF);
    set_src(1, 1'b1, 11'h101, 32'hA0000001, 4'h3);
    set_src(2, 1'b1, 11'h102, 32'hA0000002, 4'h0);  // BE=0 beat still written
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      REQ = 3'b111;
      #1;
      e = N'(1 << (c % N));
      checks++;
      if (GNT !== e) begin errors++; $display("FAIL rotation_gnt cycle=%0d got=%b exp=%b", c, GNT, e); end
      push_src(c % N);
    end
    @(negedge CLK);
    REQ = '0;
  endtask

  task automatic test_burst_lock();
    apply_reset();
    @(negedge CLK);
    set_src(0, 1'b1, 11'h010, 32'h11110000, 4'hF);
    REQ = 3'b001;
    #1;
    checks++;
    if (GNT !== 3'b001) begin errors++; $display("FAIL burst_pre_gnt got=%b exp=001", GNT); end
    push_src(0);
    @(negedge CLK);
    set_src(0, 1'b1, 11'h020, 32'h22220000, 4'hF);
    set_src(2, 1'b1, 11'h030, 32'h33330000, 4'hC);
    set_src(1, 1'b0, 11'h050, 32'hB0000050, 4'hF);
    REQ = 3'b111;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        @(negedge CLK);
        set_src(1, (k == 3), 11'(11'h050 + k), 32'hB0000050 + 32'(k), 4'hF);
      end
      #1;
      checks++;
      if (GNT !== 3'b010) begin errors++; $display("FAIL burst_gnt beat=%0d got=%b exp=010", k, GNT); end
      checks++;
      if (BUSY !== (k > 0)) begin errors++; $display("FAIL burst_busy beat=%0d got=%b exp=%b", k, BUSY, (k > 0)); end
      push_src(1);
    end
    @(negedge CLK);
    REQ = 3'b101;
    #1;
    checks++;
    if (GNT !== 3'b100) begin errors++; $display("FAIL burst_next_gnt got=%b exp=100", GNT); end
    checks++;
    if (BUSY !== 1'b0) begin errors++; $display("FAIL burst_busy_end got=%b exp=0", BUSY); end
    push_src(2);
    @(negedge CLK);
    REQ = '0;
  endtask

  task automatic test_timeout();
    apply_reset();
    @(negedge CLK);
    set_src(0, 1'b0, 11'h200, 32'hC0000000, 4'hF);
    set_src(1, 1'b1, 11'h210, 32'hC0000010, 4'h5);
    REQ = 3'b001;
    #1;
    checks++;
    if (GNT !== 3'b001) begin errors++; $display("FAIL timeout_lock_gnt got=%b exp=001", GNT); end
    push_src(0);
    for (int k = 1; k <= 15; k++) begin
      @(negedge CLK);
      REQ = 3'b010;
      #1;
      checks++;
      if ({GNT, BUSY} !== {3'b000, 1'b1})
        begin errors++; $display("FAIL timeout_stall idle=%0d got gnt=%b busy=%b exp gnt=000 busy=1", k, GNT, BUSY); end
    end
    @(negedge CLK);
    #1;
    checks++;
    if ({GNT, BUSY} !== {3'b010, 1'b0})
      begin errors++; $display("FAIL timeout_release got gnt=%b busy=%b exp gnt=010 busy=0", GNT, BUSY); end
    push_src(1);
    @(negedge CLK);
    REQ = '0;
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      set_src(0, 1'b0, 11'(11'h300 + k), 32'hD0000000 + 32'(k), 4'hF);
      REQ = 3'b001;
      #1;
      checks++;
      if (GNT !== 3'b001) begin errors++; $display("FAIL rstmid_gnt beat=%0d got=%b exp=001", k, GNT); end
      if (k < 2) push_src(0);
    end
    #2;
    RESET_N = 1'b0;
    #1;
    checks++;
    if ({GNT, RAM_WREN, RAM_WADDR, RAM_WDATA, RAM_BE, BUSY} !== '0)
      begin errors++; $display("FAIL rstmid_async got gnt=%b wren=%b addr=%h data=%h be=%h busy=%b exp all 0", GNT, RAM_WREN, RAM_WADDR, RAM_WDATA, RAM_BE, BUSY); end
    @(negedge CLK);
    set_src(1, 1'b1, 11'h401, 32'hE0000001, 4'hF);
    set_src(2, 1'b1, 11'h402, 32'hE0000002, 4'hF);
    REQ = 3'b110;
    RESET_N = 1'b1;
    #1;
    checks++;
    if (GNT !== 3'b010) begin errors++; $display("FAIL rstmid_first got=%b exp=010", GNT); end
    push_src(1);
    @(negedge CLK);
    #1;
    checks++;
    if (GNT !== 3'b100) begin errors++; $display("FAIL rstmid_second got=%b exp=100", GNT); end
    push_src(2);
    @(negedge CLK);
    REQ = '0;
  endtask

`ifdef VRAM_ARB_VBLANK_GATE_EN
  task automatic test_blank_gate();
    apply_reset();
    set_src(0, 1'b1, 11'h500, 32'hF0000000, 4'hF);
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      BLANK_IN = 1'b0;
      REQ = 3'b001;
      #1;
      checks++;
      if (GNT !== 3'b000) begin errors++; $display("FAIL gate_hold cycle=%0d got=%b exp=000", k, GNT); end
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      BLANK_IN = (k == 0);
      set_src(0, (k == 2), 11'(11'h510 + k), 32'hF0000010 + 32'(k), 4'hF);
      #1;
      checks++;
      if (GNT !== 3'b001) begin errors++; $display("FAIL gate_burst beat=%0d got=%b exp=001", k, GNT); end
      push_src(0);
    end
    @(negedge CLK);
    set_src(0, 1'b1, 11'h520, 32'hF0000020, 4'hF);
    #1;
    checks++;
    if (GNT !== 3'b000) begin errors++; $display("FAIL gate_regate got=%b exp=000", GNT); end
    @(negedge CLK);
    REQ = '0;
    BLANK_IN = 1'b1;
  endtask
`else
  task automatic test_blank_ignored();
    apply_reset();
    @(negedge CLK);
    BLANK_IN = 1'b0;
    set_src(0, 1'b1, 11'h600, 32'h60000000, 4'h9);
    REQ = 3'b001;
    #1;
    checks++;
    if (GNT !== 3'b001) begin errors++; $display("FAIL blank_ignored got=%b exp=001", GNT); end
    push_src(0);
    @(negedge CLK);
    REQ = '0;
    BLANK_IN = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_single_beat();
    test_rotation();
    test_burst_lock();
    test_timeout();
    test_reset_mid_burst();
`ifdef VRAM_ARB_VBLANK_GATE_EN
    test_blank_gate();
`else
    test_blank_ignored();
`endif
    repeat (3) @(negedge CLK);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL sb_drain got=%0d pending writes exp=0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
